// File: rtl/music_box_state_sequencer_if.sv
// Bus between the music box mode sequencer and its surroundings: button debouncers,
// the 1 kHz tick source and the per-mode state modules that report completion.
interface music_box_state_sequencer_if;
    logic        tick_1Khz;
    logic [3:0]  request;
    logic        abort;
    logic [3:0]  stateComplete;
    logic [4:0]  currentState;
    logic        stateEnter;
    logic        busy;
    logic        hasRecording;
    logic        timeoutPulse;
    logic [31:0] debugString;

    modport master (
        output tick_1Khz,
        output request,
        output abort,
        output stateComplete,
        input  currentState,
        input  stateEnter,
        input  busy,
        input  hasRecording,
        input  timeoutPulse,
        input  debugString
    );

    modport slave (
        input  tick_1Khz,
        input  request,
        input  abort,
        input  stateComplete,
        output currentState,
        output stateEnter,
        output busy,
        output hasRecording,
        output timeoutPulse,
        output debugString
    );
endinterface

// File: rtl/music_box_state_sequencer.sv
// Music box mode sequencer: turns request button edges into a currentState code held until
// completion or abort, plus a watchdog timeout when MUSICBOX_WATCHDOG_EN is defined.
module music_box_state_sequencer #(
    parameter int unsigned HOLDOFF_MS = 2,
    parameter int unsigned TIMEOUT_MS = 10000
) (
    input logic                        clock_50Mhz,
    input logic                        reset_n,
    music_box_state_sequencer_if.slave bus
);

`ifdef MUSICBOX_WATCHDOG_EN
    localparam bit WATCHDOG_EN = 1'b1;
`else
    localparam bit WATCHDOG_EN = 1'b0;
`endif

    localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF_MS);
    localparam logic [15:0] ELAPSED_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_MAKE_RECORDING = 3'd1,
        ST_PLAY_RECORDING = 3'd2,
        ST_PLAY_SONG_A    = 3'd3,
        ST_PLAY_SONG_B    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  request_q;
    logic [3:0]  request_rise;
    logic [3:0]  request_eligible;
    logic [15:0] elapsed_ms;
    logic [15:0] elapsed_next;
    logic [15:0] holdoff_cnt;
    logic [15:0] holdoff_next;
    logic        has_recording;
    logic        has_recording_next;
    logic        state_enter;
    logic        state_enter_next;
    logic        completion_flag;
    logic        limit_reached;
    logic        watchdog_hit;
    logic        exit_now;

    assign request_rise     = bus.request & ~request_q;
    // PlayRecording cannot start without a recording; masking it lets a lower-priority rise win.
    assign request_eligible = request_rise & {2'b11, has_recording, 1'b1};

    assign limit_reached = ({16'd0, elapsed_ms} == TIMEOUT_MS);
    assign watchdog_hit  = WATCHDOG_EN & limit_reached;

    always_comb begin
        completion_flag = 1'b0;
        case (state)
            ST_MAKE_RECORDING: completion_flag = bus.stateComplete[0];
            ST_PLAY_RECORDING: completion_flag = bus.stateComplete[1];
            ST_PLAY_SONG_A:    completion_flag = bus.stateComplete[2];
            ST_PLAY_SONG_B:    completion_flag = bus.stateComplete[3];
            default:           completion_flag = 1'b0;
        endcase
    end

    assign exit_now = (state != ST_IDLE) & (bus.abort | completion_flag | watchdog_hit);

    always_comb begin
        state_next         = state;
        state_enter_next   = 1'b0;
        elapsed_next       = elapsed_ms;
        holdoff_next       = holdoff_cnt;
        has_recording_next = has_recording;
        case (state)
            ST_IDLE: begin
                if (holdoff_cnt != 16'd0) begin
                    if (bus.tick_1Khz) begin
                        holdoff_next = holdoff_cnt - 16'd1;
                    end
                end else if (request_eligible != 4'd0) begin
                    state_enter_next = 1'b1;
                    elapsed_next     = 16'd0;
                    if (request_eligible[0]) begin
                        state_next         = ST_MAKE_RECORDING;
                        has_recording_next = 1'b0;
                    end else if (request_eligible[1]) begin
                        state_next = ST_PLAY_RECORDING;
                    end else if (request_eligible[2]) begin
                        state_next = ST_PLAY_SONG_A;
                    end else begin
                        state_next = ST_PLAY_SONG_B;
                    end
                end
            end
            default: begin
                if (exit_now) begin
                    state_next   = ST_IDLE;
                    holdoff_next = HOLDOFF_LOAD;
                    // Abort outranks completion, so an aborted recording stays invalid.
                    if (!bus.abort && completion_flag && state == ST_MAKE_RECORDING) begin
                        has_recording_next = 1'b1;
                    end
                end else if (bus.tick_1Khz && elapsed_ms != ELAPSED_MAX) begin
                    elapsed_next = elapsed_ms + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            request_q     <= 4'd0;
            elapsed_ms    <= 16'd0;
            holdoff_cnt   <= 16'd0;
            has_recording <= 1'b0;
            state_enter   <= 1'b0;
        end else begin
            request_q     <= bus.request;
            elapsed_ms    <= elapsed_next;
            holdoff_cnt   <= holdoff_next;
            has_recording <= has_recording_next;
            state_enter   <= state_enter_next;
        end
    end

    generate
        if (WATCHDOG_EN) begin : g_watchdog
            logic timeout_pulse_q;

            always_ff @(posedge clock_50Mhz or negedge reset_n) begin
                if (!reset_n) begin
                    timeout_pulse_q <= 1'b0;
                end else begin
                    timeout_pulse_q <= exit_now & ~bus.abort & ~completion_flag;
                end
            end

            assign bus.timeoutPulse = timeout_pulse_q;

            a_timeout_in_idle: assert property (
                @(posedge clock_50Mhz) disable iff (!reset_n)
                timeout_pulse_q |-> (state == ST_IDLE)
            );
        end else begin : g_no_watchdog
            assign bus.timeoutPulse = 1'b0;
        end
    endgenerate

    assign bus.currentState = {2'b00, state};
    assign bus.stateEnter   = state_enter;
    assign bus.busy         = (state != ST_IDLE) | (holdoff_cnt != 16'd0);
    assign bus.hasRecording = has_recording;
    assign bus.debugString  = {11'd0, 2'b00, state, elapsed_ms};

    a_enter_is_active: assert property (
        @(posedge clock_50Mhz) disable iff (!reset_n)
        state_enter |-> (state != ST_IDLE)
    );

    a_state_legal: assert property (
        @(posedge clock_50Mhz) disable iff (!reset_n)
        state <= ST_PLAY_SONG_B
    );

endmodule

// File: tb/tb_music_box_state_sequencer.sv
// Self-checking bench for music_box_state_sequencer: directed scenarios plus random traffic,
// every output compared each cycle against a behavioural model of the mode rules.
module tb_music_box_state_sequencer;

    localparam int HOLDOFF_MS = 2;
    localparam int TIMEOUT_MS = 10;
`ifdef MUSICBOX_WATCHDOG_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif

    logic clock_50Mhz;
    logic reset_n;

    music_box_state_sequencer_if bus ();

    music_box_state_sequencer #(
        .HOLDOFF_MS (HOLDOFF_MS),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .bus         (bus.slave)
    );

    initial begin
        clock_50Mhz = 1'b0;
        forever #10 clock_50Mhz = ~clock_50Mhz;
    end

    int total_checks = 0;
    int bad_checks   = 0;

    // Model: which mode is running, ms spent in it, remaining holdoff, recording validity.
    int         m_mode;
    int         m_elapsed;
    int         m_holdoff;
    bit         m_has_rec;
    bit         m_enter;
    bit         m_timeout;
    logic [3:0] m_req_prev;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    function automatic void modelReset();
        m_mode     = 0;
        m_elapsed  = 0;
        m_holdoff  = 0;
        m_has_rec  = 1'b0;
        m_enter    = 1'b0;
        m_timeout  = 1'b0;
        m_req_prev = 4'd0;
    endfunction

    function automatic void modelStep();
        logic [3:0] rise;
        bit         done;
        rise       = bus.request & ~m_req_prev;
        m_req_prev = bus.request;
        m_enter    = 1'b0;
        m_timeout  = 1'b0;
        if (m_mode == 0) begin
            if (m_holdoff > 0) begin
                if (bus.tick_1Khz) m_holdoff = m_holdoff - 1;
            end else begin
                if (!m_has_rec) rise[1] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (rise[i] && !m_enter) begin
                        m_mode    = i + 1;
                        m_elapsed = 0;
                        m_enter   = 1'b1;
                        if (i == 0) m_has_rec = 1'b0;
                    end
                end
            end
        end else begin
            done = bus.stateComplete[m_mode - 1];
            if (bus.abort || done || (WATCHDOG && m_elapsed == TIMEOUT_MS)) begin
                if (!bus.abort && done && m_mode == 1) m_has_rec = 1'b1;
                if (!bus.abort && !done) m_timeout = 1'b1;
                m_mode    = 0;
                m_holdoff = HOLDOFF_MS;
            end else if (bus.tick_1Khz && m_elapsed < 65535) begin
                m_elapsed = m_elapsed + 1;
            end
        end
    endfunction

    task automatic compareAll();
        checkOutput("currentState", 32'(bus.currentState), 32'(m_mode));
        checkOutput("stateEnter", 32'(bus.stateEnter), 32'(m_enter));
        checkOutput("busy", 32'(bus.busy), 32'(m_mode != 0 || m_holdoff != 0));
        checkOutput("hasRecording", 32'(bus.hasRecording), 32'(m_has_rec));
        checkOutput("timeoutPulse", 32'(bus.timeoutPulse), 32'(m_timeout));
        checkOutput("debugString", bus.debugString, {11'd0, 5'(m_mode), 16'(m_elapsed)});
    endtask

    task automatic runCycle();
        @(posedge clock_50Mhz);
        if (!reset_n) modelReset();
        else modelStep();
        @(negedge clock_50Mhz);
        compareAll();
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic abrt, input logic [3:0] cmpl, input logic tck);
        bus.request       = req;
        bus.abort         = abrt;
        bus.stateComplete = cmpl;
        bus.tick_1Khz     = tck;
        runCycle();
    endtask

    // Leaves the sequencer in IDLE with the holdoff drained and no requests held.
    task automatic settleIdle();
        applyStimulus(4'd0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'd0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic asyncReset();
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_currentState", 32'(bus.currentState), 32'd0);
        checkOutput("rst_hasRecording", 32'(bus.hasRecording), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_debugString", bus.debugString, 32'd0);
        modelReset();
        runCycle();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rnd_req;
        logic [3:0] rnd_cmpl;
        logic       rnd_abort;
        logic       rnd_tick;

        reset_n           = 1'b0;
        bus.request       = 4'd0;
        bus.abort         = 1'b0;
        bus.stateComplete = 4'd0;
        bus.tick_1Khz     = 1'b0;
        modelReset();
        $display("[TB] start, watchdog=%0d", WATCHDOG);

        for (int i = 0; i < 3; i++) runCycle();
        reset_n = 1'b1;

        // PlayRecording with no recording is ignored
        settleIdle();
        applyStimulus(4'b0010, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b0);

        // Recording of 5000 ms, then completion
        settleIdle();
        applyStimulus(4'b0001, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5000; i++) applyStimulus(4'd0, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'd0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0);

        // PlayRecording now allowed if the recording completed
        settleIdle();
        applyStimulus(4'b0010, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 4'b0010, 1'b0);

        // Simultaneous rises on 3 and 2, then request[0] toggles while active
        settleIdle();
        applyStimulus(4'b1100, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b1101, 1'b0, 4'b1011, 1'b0);
        applyStimulus(4'b1100, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'b1101, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'b0100, 1'b0);

        // Abort and completion together in SongB, then holdoff masking
        settleIdle();
        applyStimulus(4'b1000, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 4'b1000, 1'b0);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(4'b0000, 1'b0, 4'd0, 1'b0);
            applyStimulus(4'b0100, 1'b0, 4'd0, 1'b1);
        end
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 4'd0, 1'b0);

        // SongA left running: watchdog exit, or persistence past 10000 ms
        settleIdle();
        applyStimulus(4'b0100, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10050; i++) applyStimulus(4'd0, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'd0, 1'b1, 4'd0, 1'b0);

        // Asynchronous reset in the middle of a recording
        settleIdle();
        applyStimulus(4'b0001, 1'b0, 4'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 4'd0, 1'b1);
        asyncReset();

        // Random traffic
        rnd_req = 4'd0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 15) == 0) rnd_req[b] = ~rnd_req[b];
                rnd_cmpl[b] = ($urandom_range(0, 31) == 0);
            end
            rnd_abort = ($urandom_range(0, 63) == 0);
            rnd_tick  = ($urandom_range(0, 3) == 0);
            applyStimulus(rnd_req, rnd_abort, rnd_cmpl, rnd_tick);
            if (c == 2000) asyncReset();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
